// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard bus. Register identifiers and stage status flow in from the pipeline,
// and stall, flush and forward controls plus performance counters flow back out.
interface hazard_scoreboard_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic              RegWriteE, PCSrcE, RegWriteM, MemValidM, MemReadyM, RegWriteW;
  logic [1:0]        ResultSrcE;
  logic              StallF, StallD, StallE, StallM;
  logic              FlushD, FlushE, FlushW, MemTimeout;
  logic [1:0]        ForwardAE, ForwardBE;
  logic [CNT_W-1:0]  StallCycles, FlushEvents;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteE, PCSrcE, RegWriteM, MemValidM, MemReadyM, RegWriteW, ResultSrcE,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout,
    input  ForwardAE, ForwardBE, StallCycles, FlushEvents
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteE, PCSrcE, RegWriteM, MemValidM, MemReadyM, RegWriteW, ResultSrcE,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout,
    output ForwardAE, ForwardBE, StallCycles, FlushEvents
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: load-use / RAW interlock, bypass select, memory-wait stall with a
// sticky timeout, and saturating stall/flush event counters.
module hazard_scoreboard #(
  parameter int ADDR_W  = 5,
  parameter int FWD_EN  = 1,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  hazard_scoreboard_if.slave sb
);
  localparam int                WAIT_W   = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [ADDR_W-1:0] REG_ZERO = {ADDR_W{1'b0}};

  function automatic logic src_hit(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] rd,
                                   input logic we);
    return we && (src == rd) && (src != REG_ZERO);
  endfunction

  // The memory-stage ALU result is younger than writeback, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] src,
                                         input logic [ADDR_W-1:0] rd_m, input logic we_m,
                                         input logic [ADDR_W-1:0] rd_w, input logic we_w);
    if (src_hit(src, rd_m, we_m)) begin
      return 2'b10;
    end else if (src_hit(src, rd_w, we_w)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  logic              mem_stall_s, lw_stall_s, dep_stall_s, raw_stall_s;
  logic [1:0]        fwd_a_s, fwd_b_s;
  logic              stall_f_s, stall_d_s, stall_e_s, stall_m_s;
  logic              flush_d_s, flush_e_s, flush_w_s;
  logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_nxt_s;
  logic              mem_timeout_r, mem_timeout_nxt_s;
  logic [CNT_W-1:0]  stall_cnt_r, stall_cnt_nxt_s, flush_cnt_r, flush_cnt_nxt_s;

  // Hazard detection and bypass selection.
  always_comb begin
    mem_stall_s = sb.MemValidM & ~sb.MemReadyM;
    lw_stall_s  = (sb.ResultSrcE == 2'b01) && (sb.RdE != REG_ZERO) &&
                  ((sb.Rs1D == sb.RdE) || (sb.Rs2D == sb.RdE));
    dep_stall_s = src_hit(sb.Rs1D, sb.RdE, sb.RegWriteE) | src_hit(sb.Rs2D, sb.RdE, sb.RegWriteE) |
                  src_hit(sb.Rs1D, sb.RdM, sb.RegWriteM) | src_hit(sb.Rs2D, sb.RdM, sb.RegWriteM) |
                  src_hit(sb.Rs1D, sb.RdW, sb.RegWriteW) | src_hit(sb.Rs2D, sb.RdW, sb.RegWriteW);
    if (FWD_EN != 0) begin
      raw_stall_s = lw_stall_s;
      fwd_a_s     = fwd_sel(sb.Rs1E, sb.RdM, sb.RegWriteM, sb.RdW, sb.RegWriteW);
      fwd_b_s     = fwd_sel(sb.Rs2E, sb.RdM, sb.RegWriteM, sb.RdW, sb.RegWriteW);
    end else begin
      raw_stall_s = dep_stall_s;
      fwd_a_s     = 2'b00;
      fwd_b_s     = 2'b00;
    end
  end

  // Stall/flush controls; a memory wait freezes everything up to M and bubbles W.
  always_comb begin
    stall_f_s = 1'b0;
    stall_d_s = 1'b0;
    stall_e_s = 1'b0;
    stall_m_s = 1'b0;
    flush_d_s = 1'b0;
    flush_e_s = 1'b0;
    flush_w_s = 1'b0;
    if (reset) begin
      flush_d_s = 1'b1;
      flush_e_s = 1'b1;
      flush_w_s = 1'b1;
    end else if (mem_stall_s) begin
      stall_f_s = 1'b1;
      stall_d_s = 1'b1;
      stall_e_s = 1'b1;
      stall_m_s = 1'b1;
      flush_w_s = 1'b1;
    end else begin
      stall_f_s = raw_stall_s;
      stall_d_s = raw_stall_s;
      flush_e_s = raw_stall_s | sb.PCSrcE;
      flush_d_s = sb.PCSrcE;
    end
  end

  // Next-state for the wait counter, timeout flag and event counters.
  always_comb begin
    wait_cnt_nxt_s = {WAIT_W{1'b0}};
    if (!mem_stall_s) begin
      wait_cnt_nxt_s = {WAIT_W{1'b0}};
    end else if (wait_cnt_r == WAIT_MAX) begin
      wait_cnt_nxt_s = WAIT_MAX;
    end else begin
      wait_cnt_nxt_s = wait_cnt_r + 1'b1;
    end
    mem_timeout_nxt_s = mem_timeout_r | (mem_stall_s & (wait_cnt_nxt_s == WAIT_MAX));
    if (stall_f_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_nxt_s = stall_cnt_r + 1'b1;
    end else begin
      stall_cnt_nxt_s = stall_cnt_r;
    end
    if (sb.PCSrcE && !mem_stall_s && (flush_cnt_r != CNT_MAX)) begin
      flush_cnt_nxt_s = flush_cnt_r + 1'b1;
    end else begin
      flush_cnt_nxt_s = flush_cnt_r;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_r    <= {WAIT_W{1'b0}};
      mem_timeout_r <= 1'b0;
      stall_cnt_r   <= {CNT_W{1'b0}};
      flush_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      wait_cnt_r    <= wait_cnt_nxt_s;
      mem_timeout_r <= mem_timeout_nxt_s;
      stall_cnt_r   <= stall_cnt_nxt_s;
      flush_cnt_r   <= flush_cnt_nxt_s;
    end
  end

  assign sb.StallF      = stall_f_s;
  assign sb.StallD      = stall_d_s;
  assign sb.StallE      = stall_e_s;
  assign sb.StallM      = stall_m_s;
  assign sb.FlushD      = flush_d_s;
  assign sb.FlushE      = flush_e_s;
  assign sb.FlushW      = flush_w_s;
  assign sb.ForwardAE   = reset ? 2'b00 : fwd_a_s;
  assign sb.ForwardBE   = reset ? 2'b00 : fwd_b_s;
  assign sb.MemTimeout  = mem_timeout_r;
  assign sb.StallCycles = stall_cnt_r;
  assign sb.FlushEvents = flush_cnt_r;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: dut0 bypasses (TIMEOUT=4, CNT_W=4), dut1 interlocks only (defaults otherwise);
// both see identical pipeline inputs.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.ADDR_W(5), .CNT_W(4))  bus0 ();
  hazard_scoreboard_if #(.ADDR_W(5), .CNT_W(16)) bus1 ();

  hazard_scoreboard #(.ADDR_W(5), .FWD_EN(1), .TIMEOUT(4), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .sb(bus0));
  hazard_scoreboard #(.ADDR_W(5), .FWD_EN(0), .TIMEOUT(16), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .sb(bus1));

  assign bus1.Rs1D = bus0.Rs1D;           assign bus1.Rs2D = bus0.Rs2D;
  assign bus1.Rs1E = bus0.Rs1E;           assign bus1.Rs2E = bus0.Rs2E;
  assign bus1.RdE = bus0.RdE;             assign bus1.RegWriteE = bus0.RegWriteE;
  assign bus1.ResultSrcE = bus0.ResultSrcE; assign bus1.PCSrcE = bus0.PCSrcE;
  assign bus1.RdM = bus0.RdM;             assign bus1.RegWriteM = bus0.RegWriteM;
  assign bus1.MemValidM = bus0.MemValidM; assign bus1.MemReadyM = bus0.MemReadyM;
  assign bus1.RdW = bus0.RdW;             assign bus1.RegWriteW = bus0.RegWriteW;

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
    logic       rwe;
    logic [1:0] rse;
    logic       pcs;
    logic [4:0] rdm;
    logic       rwm, mv, mr;
    logic [4:0] rdw;
    logic       rww;
    logic [3:0] st0;  // {StallF,StallD,StallE,StallM}
    logic [2:0] fl0;  // {FlushD,FlushE,FlushW}
    logic [1:0] fa0, fb0;
    logic [3:0] st1;
    logic [2:0] fl1;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    bus0.Rs1D = v.rs1d; bus0.Rs2D = v.rs2d; bus0.Rs1E = v.rs1e; bus0.Rs2E = v.rs2e;
    bus0.RdE = v.rde; bus0.RegWriteE = v.rwe; bus0.ResultSrcE = v.rse; bus0.PCSrcE = v.pcs;
    bus0.RdM = v.rdm; bus0.RegWriteM = v.rwm; bus0.MemValidM = v.mv; bus0.MemReadyM = v.mr;
    bus0.RdW = v.rdw; bus0.RegWriteW = v.rww;
  endtask

  task automatic idle();
    vec_t z;
    z = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0,
          4'b0000, 3'b000, 2'b00, 2'b00, 4'b0000, 3'b000};
    apply(z);
  endtask

  task automatic load_use(input logic [4:0] rde, input logic pcs);
    bus0.Rs1D = 5'd5; bus0.RdE = rde; bus0.RegWriteE = 1'b1; bus0.ResultSrcE = 2'b01;
    bus0.PCSrcE = pcs;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; idle(); tick(); reset = 1'b0;
  endtask

  function automatic logic [3:0] st(input logic f, input logic d, input logic e, input logic m);
    return {f, d, e, m};
  endfunction

  initial begin
    //            rs1d  rs2d  rs1e  rs2e  rde   rwe   rse    pcs   rdm   rwm   mv    mr    rdw   rww     st0      fl0     fa0    fb0    st1      fl1
    vecs[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b0000, 3'b000, 2'b00, 2'b00, 4'b0000, 3'b000};
    vecs[1]  = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 1'b1, 2'b01, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b1100, 3'b010, 2'b00, 2'b00, 4'b1100, 3'b010};
    vecs[2]  = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 2'b01, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b0000, 3'b000, 2'b00, 2'b00, 4'b0000, 3'b000};
    vecs[3]  = '{5'd0, 5'd9, 5'd0, 5'd0, 5'd9, 1'b1, 2'b01, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b1100, 3'b010, 2'b00, 2'b00, 4'b1100, 3'b010};
    vecs[4]  = '{5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 1'b1, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b0000, 3'b000, 2'b00, 2'b00, 4'b1100, 3'b010};
    vecs[5]  = '{5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 4'b0000, 3'b000, 2'b10, 2'b00, 4'b0000, 3'b000};
    vecs[6]  = '{5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 4'b0000, 3'b000, 2'b01, 2'b00, 4'b0000, 3'b000};
    vecs[7]  = '{5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 1'b0, 2'b00, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 4'b0000, 3'b000, 2'b00, 2'b10, 4'b0000, 3'b000};
    vecs[8]  = '{5'd0, 5'd0, 5'd2, 5'd6, 5'd0, 1'b0, 2'b00, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 5'd6, 1'b1, 4'b0000, 3'b000, 2'b10, 2'b01, 4'b0000, 3'b000};
    vecs[9]  = '{5'd0, 5'd7, 5'd0, 5'd7, 5'd0, 1'b0, 2'b00, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 4'b0000, 3'b000, 2'b00, 2'b10, 4'b1100, 3'b010};
    vecs[10] = '{5'd8, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 4'b0000, 3'b000, 2'b00, 2'b00, 4'b1100, 3'b010};
    vecs[11] = '{5'd8, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0, 4'b0000, 3'b000, 2'b00, 2'b00, 4'b0000, 3'b000};
    vecs[12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b0000, 3'b110, 2'b00, 2'b00, 4'b0000, 3'b110};
    vecs[13] = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 1'b1, 2'b01, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b1100, 3'b110, 2'b00, 2'b00, 4'b1100, 3'b110};
    vecs[14] = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 1'b1, 2'b01, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 4'b1111, 3'b001, 2'b00, 2'b00, 4'b1111, 3'b001};
    vecs[15] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 4'b0000, 3'b000, 2'b00, 2'b00, 4'b0000, 3'b000};
    vecs[16] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 4'b0000, 3'b000, 2'b00, 2'b00, 4'b0000, 3'b000};
    vecs[17] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 2'b00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 4'b0000, 3'b000, 2'b00, 2'b00, 4'b0000, 3'b000};

    // Reset dominates active hazards and clears all state.
    reset = 1'b1;
    idle();
    tick();
    load_use(5'd5, 1'b1);
    bus0.MemValidM = 1'b1; bus0.Rs1E = 5'd3; bus0.RdM = 5'd3; bus0.RegWriteM = 1'b1;
    #2;
    chk("rst_stall0", 0, 16'(st(bus0.StallF, bus0.StallD, bus0.StallE, bus0.StallM)), 16'h0);
    chk("rst_flush0", 0, 16'({bus0.FlushD, bus0.FlushE, bus0.FlushW}), 16'h7);
    chk("rst_fwd0", 0, 16'({bus0.ForwardAE, bus0.ForwardBE}), 16'h0);
    chk("rst_stall1", 0, 16'(st(bus1.StallF, bus1.StallD, bus1.StallE, bus1.StallM)), 16'h0);
    chk("rst_flush1", 0, 16'({bus1.FlushD, bus1.FlushE, bus1.FlushW}), 16'h7);
    tick();
    chk("rst_cnt0", 0, 16'({bus0.StallCycles, bus0.FlushEvents, 3'b000, bus0.MemTimeout}), 16'h0);
    chk("rst_cnt1", 0, bus1.StallCycles | bus1.FlushEvents | 16'(bus1.MemTimeout), 16'h0);
    reset = 1'b0;
    idle();
    tick();

    for (int i = 0; i < 18; i++) begin
      apply(vecs[i]);
      #2;
      chk("stall0", i, 16'(st(bus0.StallF, bus0.StallD, bus0.StallE, bus0.StallM)), 16'(vecs[i].st0));
      chk("flush0", i, 16'({bus0.FlushD, bus0.FlushE, bus0.FlushW}), 16'(vecs[i].fl0));
      chk("fwd0", i, 16'({bus0.ForwardAE, bus0.ForwardBE}), 16'({vecs[i].fa0, vecs[i].fb0}));
      chk("stall1", i, 16'(st(bus1.StallF, bus1.StallD, bus1.StallE, bus1.StallM)), 16'(vecs[i].st1));
      chk("flush1", i, 16'({bus1.FlushD, bus1.FlushE, bus1.FlushW}), 16'(vecs[i].fl1));
      chk("fwd1", i, 16'({bus1.ForwardAE, bus1.ForwardBE}), 16'h0);
      tick();
    end

    // Load-use counts one stall cycle; with RdE=0 nothing more is counted.
    pulse_reset();
    idle();
    tick();
    chk("lu_cnt_init", 0, 16'(bus0.StallCycles), 16'h0);
    load_use(5'd5, 1'b0);
    tick();
    chk("lu_cnt0", 0, 16'(bus0.StallCycles), 16'h1);
    chk("lu_cnt1", 0, bus1.StallCycles, 16'h1);
    load_use(5'd0, 1'b0);
    tick();
    chk("lu_rd0_cnt0", 0, 16'(bus0.StallCycles), 16'h1);

    // Three-cycle memory wait with a taken branch pending behind it.
    pulse_reset();
    idle();
    bus0.MemValidM = 1'b1; bus0.PCSrcE = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) bus0.MemReadyM = 1'b1;
      #2;
      chk("mw_stallm", k, 16'(bus0.StallM), 16'(k < 3));
      chk("mw_stallf", k, 16'(bus0.StallF), 16'(k < 3));
      chk("mw_flushw", k, 16'(bus0.FlushW), 16'(k < 3));
      chk("mw_flushd", k, 16'(bus0.FlushD), 16'(k >= 3));
      chk("mw_fev", k, 16'(bus0.FlushEvents), 16'(k == 4));
      tick();
    end
    chk("mw_scyc", 0, 16'(bus0.StallCycles), 16'h3);
    chk("mw_fev_end", 0, 16'(bus0.FlushEvents), 16'h2);

    // Timeout after 4 wait edges, sticky, cleared by reset, and recounted from zero.
    pulse_reset();
    idle();
    bus0.MemValidM = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("to_flag0", k, 16'(bus0.MemTimeout), 16'(k >= 4));
      chk("to_flag1", k, 16'(bus1.MemTimeout), 16'h0);
    end
    chk("to_still_stall", 0, 16'(bus0.StallM), 16'h1);
    reset = 1'b1;
    #1;
    chk("to_rst_stall", 0, 16'(bus0.StallM), 16'h0);
    tick();
    chk("to_rst_flag", 0, 16'(bus0.MemTimeout), 16'h0);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("to_recount", k, 16'(bus0.MemTimeout), 16'(k == 4));
    end

    // Counter saturation: 20 stall+branch cycles.
    pulse_reset();
    idle();
    load_use(5'd5, 1'b1);
    repeat (20) tick();
    chk("sat_scyc0", 0, 16'(bus0.StallCycles), 16'd15);
    chk("sat_fev0", 0, 16'(bus0.FlushEvents), 16'd15);
    chk("sat_scyc1", 0, bus1.StallCycles, 16'd20);
    chk("sat_fev1", 0, bus1.FlushEvents, 16'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
